status_tx: RTL and testbench

- Serial status reporter: the outbound direction of the UART command link that sets waveform state, frequency, amplitude and phase.
- On a report request it snapshots the current state_sel outputs and formats them as a fixed 21-character ASCII line.
- Sends the line 8N1, LSB first, on tx back to the host terminal.

---
 rtl/status_pkg.sv | 67 ++++++
 rtl/status_tx_uart.sv | 107 ++++++++++
 rtl/status_tx.sv | 124 ++++++++++++
 tb/tb_status_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/status_pkg.sv
// status_pkg: shared definitions for the serial status reporter.
//   - ASCII constants used to build the report line
//   - message length and character-index width
//   - UART byte FSM state encoding
//   - snapshot record and binary-to-BCD / ASCII digit helpers
package status_pkg;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;

  localparam int unsigned MSG_LEN = 21;
  localparam int unsigned IDX_W   = 5;

  // ST_NEXT takes zero cycles: the inter-character decision is made on the
  // STOP exit edge, so the byte FSM never actually rests in it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } tx_state_e;

  typedef struct packed {
    logic [4:0]  state;
    logic [11:0] freq;
    logic [7:0]  amp;
    logic [7:0]  phase;
  } snap_t;

  // Double-dabble: 12-bit binary to four packed BCD digits.
  function automatic logic [15:0] bin_to_bcd(input logic [11:0] bin);
    logic [27:0] sr;
    sr = {16'b0, bin};
    for (int unsigned i = 0; i < 12; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (sr[12 + 4*d +: 4] >= 4'd5) begin
          sr[12 + 4*d +: 4] = sr[12 + 4*d +: 4] + 4'd3;
        end
      end
      sr = sr << 1;
    end
    return sr[27:12];
  endfunction

  // ASCII character of decimal digit 'pos' (0 = ones) of value v.
  function automatic logic [7:0] ascii_digit(input logic [11:0] v,
                                             input logic [1:0]  pos);
    logic [15:0] bcd;
    logic [3:0]  d;
    bcd = bin_to_bcd(v);
    case (pos)
      2'd0:    d = bcd[3:0];
      2'd1:    d = bcd[7:4];
      2'd2:    d = bcd[11:8];
      default: d = bcd[15:12];
    endcase
    return CH_0 + {4'b0, d};
  endfunction

endpackage

// File: rtl/status_tx_uart.sv
// uart_tx_byte: 8N1 serial transmitter for one byte, LSB first.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   start  in  load data and begin a start bit (accepted in IDLE, or on the
//              final STOP cycle for gapless back-to-back bytes)
//   data   in  byte to send, sampled when start is accepted
//   tx     out serial line, registered, idles high
//   done   out high during the final cycle of the STOP bit
module uart_tx_byte
  import status_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign done    = (state == ST_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (start) begin
            state <= ST_START;
            tx    <= 1'b0;
            cnt   <= '0;
            shreg <= data;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            // Exit edge of STOP doubles as the zero-length NEXT decision.
            if (start) begin
              state <= ST_START;
              tx    <= 1'b0;
              shreg <= data;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/status_tx.sv
// status_tx: on a report request, snapshots the waveform state inputs and
// sends "Sdd Fdddd Addd Pddd\r\n" (21 chars) as 8N1 serial on tx.
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   report       in  report request, sampled every cycle
//   state        in  5-bit waveform state
//   state_freq   in  12-bit frequency value
//   state_amp    in  8-bit amplitude value
//   state_phase  in  8-bit phase value
//   tx           out UART serial out, idles high
//   busy         out high while a frame is in flight
module status_tx
  import status_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        report,
  input  logic [4:0]  state,
  input  logic [11:0] state_freq,
  input  logic [7:0]  state_amp,
  input  logic [7:0]  state_phase,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  snap_t            snap;
  logic             pending;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] char_idx;
  logic [7:0]       char_data;
  logic             byte_start;
  logic             byte_done;

  // Start a character either from idle (first char, always 'S', so the
  // not-yet-loaded snapshot is irrelevant) or on the last STOP cycle of the
  // previous character for a gapless hand-off.
  always_comb begin
    byte_start = 1'b0;
    char_idx   = '0;
    if (busy) begin
      byte_start = byte_done && (index != LAST_IDX);
      char_idx   = index + IDX_W'(1);
    end else begin
      byte_start = report || pending;
    end
  end

  always_comb begin
    char_data = CH_SP;
    case (char_idx)
      5'd0:    char_data = CH_S;
      5'd1:    char_data = ascii_digit({7'b0, snap.state}, 2'd1);
      5'd2:    char_data = ascii_digit({7'b0, snap.state}, 2'd0);
      5'd3:    char_data = CH_SP;
      5'd4:    char_data = CH_F;
      5'd5:    char_data = ascii_digit(snap.freq, 2'd3);
      5'd6:    char_data = ascii_digit(snap.freq, 2'd2);
      5'd7:    char_data = ascii_digit(snap.freq, 2'd1);
      5'd8:    char_data = ascii_digit(snap.freq, 2'd0);
      5'd9:    char_data = CH_SP;
      5'd10:   char_data = CH_A;
      5'd11:   char_data = ascii_digit({4'b0, snap.amp}, 2'd2);
      5'd12:   char_data = ascii_digit({4'b0, snap.amp}, 2'd1);
      5'd13:   char_data = ascii_digit({4'b0, snap.amp}, 2'd0);
      5'd14:   char_data = CH_SP;
      5'd15:   char_data = CH_P;
      5'd16:   char_data = ascii_digit({4'b0, snap.phase}, 2'd2);
      5'd17:   char_data = ascii_digit({4'b0, snap.phase}, 2'd1);
      5'd18:   char_data = ascii_digit({4'b0, snap.phase}, 2'd0);
      5'd19:   char_data = CH_CR;
      5'd20:   char_data = CH_LF;
      default: char_data = CH_SP;
    endcase
  end

  // A request arriving while busy (including on the completion edge) is held
  // in pending; it then starts a new frame after one idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      pending <= 1'b0;
      index   <= '0;
      snap    <= '0;
    end else if (!busy) begin
      if (report || pending) begin
        snap    <= '{state: state, freq: state_freq,
                     amp: state_amp, phase: state_phase};
        index   <= '0;
        busy    <= 1'b1;
        pending <= 1'b0;
      end
    end else begin
      if (report) begin
        pending <= 1'b1;
      end
      if (byte_done) begin
        if (index == LAST_IDX) begin
          busy  <= 1'b0;
          index <= '0;
        end else begin
          index <= index + IDX_W'(1);
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (char_data),
    .tx    (tx),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_status_tx.sv
module tb_status_tx;

  logic        clk;
  logic        rst_n;
  logic        report;
  logic [4:0]  st;
  logic [11:0] fr;
  logic [7:0]  am;
  logic [7:0]  ph;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad   = 0;

  status_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .report      (report),
    .state       (st),
    .state_freq  (fr),
    .state_amp   (am),
    .state_phase (ph),
    .tx          (tx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy run-length monitor
  logic        prev_busy = 1'b0;
  int unsigned busy_run  = 0;
  int unsigned idle_run  = 0;
  int unsigned last_busy = 0;
  int unsigned last_idle = 0;

  always @(negedge clk) begin
    prev_busy <= busy;
    if (busy && !prev_busy) begin
      last_idle <= idle_run;
      busy_run  <= 1;
    end else if (busy) begin
      busy_run <= busy_run + 1;
    end
    if (!busy && prev_busy) begin
      last_busy <= busy_run;
      idle_run  <= 1;
    end else if (!busy) begin
      idle_run <= idle_run + 1;
    end
  end

  typedef struct {
    logic [4:0]   s;
    logic [11:0]  f;
    logic [7:0]   a;
    logic [7:0]   p;
    logic [167:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [167:0] got, input logic [167:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic rx_char(output logic [7:0] c, output bit ok);
    int unsigned w;
    ok = 1'b1;
    c  = '0;
    w  = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    tick(5);
    if (tx !== 1'b0) ok = 1'b0;
    for (int b = 0; b < 8; b++) begin
      tick(10);
      c[b] = tx;
    end
    tick(10);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_frame(input string name, input logic [167:0] exp);
    logic [167:0] got;
    logic [7:0]   c;
    bit           ok;
    bit           all_ok;
    got    = '0;
    all_ok = 1'b1;
    for (int i = 0; i < 21; i++) begin
      rx_char(c, ok);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
      got[167 - 8*i -: 8] = c;
    end
    check({name, "_sync"}, {31'b0, all_ok}, 32'd1);
    check_frame(name, got, exp);
  endtask

  task automatic quiet(input string name, input int n);
    int act;
    act = 0;
    repeat (n) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    check(name, act, 0);
  endtask

  task automatic set_vals(input logic [4:0] s, input logic [11:0] f,
                          input logic [7:0] a, input logic [7:0] p);
    st = s; fr = f; am = a; ph = p;
  endtask

  // report pulse; start bit must already be on tx one edge later
  task automatic kick(input string name);
    report = 1'b1;
    tick(1);
    report = 1'b0;
    check({name, "_lat_tx"}, {31'b0, tx}, 32'd0);
    check({name, "_lat_busy"}, {31'b0, busy}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'd3,  12'd1000, 8'd50,  8'd50,  "S03 F1000 A050 P050\r\n"};
    tbl[1] = '{5'd31, 12'd4095, 8'd255, 8'd255, "S31 F4095 A255 P255\r\n"};
    tbl[2] = '{5'd0,  12'd0,    8'd0,   8'd0,   "S00 F0000 A000 P000\r\n"};
    tbl[3] = '{5'd7,  12'd59,   8'd9,   8'd128, "S07 F0059 A009 P128\r\n"};

    rst_n  = 1'b0;
    report = 1'b0;
    set_vals(5'd0, 12'd0, 8'd0, 8'd0);

    // 1: reset and idle
    tick(3);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    quiet("idle_quiet", 50);

    // 2/3: table of single frames
    for (int i = 0; i < 4; i++) begin
      set_vals(tbl[i].s, tbl[i].f, tbl[i].a, tbl[i].p);
      kick($sformatf("vec%0d", i));
      rx_frame($sformatf("vec%0d_frame", i), tbl[i].exp);
      tick(10);
      check($sformatf("vec%0d_busy_len", i), last_busy, 2100);
      check($sformatf("vec%0d_end_tx", i), {31'b0, tx}, 32'd1);
      check($sformatf("vec%0d_end_busy", i), {31'b0, busy}, 32'd0);
    end

    // 4: snapshot isolation and pending collapse
    set_vals(5'd1, 12'd1000, 8'd2, 8'd3);
    kick("iso");
    fork
      rx_frame("iso_frame1", "S01 F1000 A002 P003\r\n");
      begin
        tick(499);
        fr = 12'd2000;
        report = 1'b1;
        tick(1);
        report = 1'b0;
        tick(300);
        report = 1'b1;
        tick(1);
        report = 1'b0;
      end
    join
    rx_frame("iso_frame2", "S01 F2000 A002 P003\r\n");
    check("iso_gap", last_idle, 1);
    tick(10);
    check("iso_busy_len", last_busy, 2100);
    quiet("iso_collapse", 300);

    // 5: reset mid-frame (char 7, data bit 3), with a request pending
    set_vals(5'd2, 12'd222, 8'd22, 8'd2);
    kick("mrst");
    tick(300);
    report = 1'b1;
    tick(1);
    report = 1'b0;
    tick(444);
    check("mrst_pre_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("mrst_tx", {31'b0, tx}, 32'd1);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    quiet("mrst_quiet", 300);
    set_vals(5'd30, 12'd2048, 8'd128, 8'd1);
    kick("mrst2");
    rx_frame("mrst2_frame", "S30 F2048 A128 P001\r\n");
    tick(10);
    check("mrst2_busy_len", last_busy, 2100);

    // 6: report held high -> back-to-back frames with 1-cycle gaps
    set_vals(5'd5, 12'd123, 8'd45, 8'd6);
    report = 1'b1;
    tick(1);
    check("hold_lat_tx", {31'b0, tx}, 32'd0);
    rx_frame("hold_frame1", "S05 F0123 A045 P006\r\n");
    set_vals(5'd16, 12'd4000, 8'd100, 8'd200);
    rx_frame("hold_frame2", "S16 F4000 A100 P200\r\n");
    check("hold_gap2", last_idle, 1);
    report = 1'b0;
    set_vals(5'd9, 12'd9, 8'd99, 8'd99);
    rx_frame("hold_frame3", "S09 F0009 A099 P099\r\n");
    check("hold_gap3", last_idle, 1);
    tick(10);
    check("hold_busy_len", last_busy, 2100);
    quiet("hold_quiet", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
